// File: rtl/can_fd_pkg.sv
// can_fd_pkg: shared CAN FD CRC field constants and types
package can_fd_pkg;
    localparam int CRC17_W = 17;
    localparam int CRC21_W = 21;
    localparam int STUFF_PERIOD = 5;
    localparam logic [4:0] LEN_17 = 5'd22;
    localparam logic [4:0] LEN_21 = 5'd27;
    typedef enum logic {CRC_17 = 1'b0, CRC_21 = 1'b1} crc_sel_e;
    typedef enum logic [1:0] {IDLE, SEND, LAST, DELIM} tx_state_e;
endpackage

// File: rtl/can_fixed_stuff_pos.sv
// can_fixed_stuff_pos: decodes fixed stuff and final positions of the CRC field
module can_fixed_stuff_pos
    import can_fd_pkg::*;
(
    input  logic [4:0] bit_cnt,
    input  crc_sel_e   crc_sel,
    output logic       is_stuff_pos,
    output logic       is_last_pos
);
    // stuff bit every STUFF_PERIOD positions from 0; last position is length-1
    always_comb begin
        is_stuff_pos = (32'(bit_cnt) % STUFF_PERIOD) == 0;
        is_last_pos  = bit_cnt == ((crc_sel == CRC_21 ? LEN_21 : LEN_17) - 5'd1);
    end
endmodule

// File: rtl/can_crc_stuff.sv
// can_crc_stuff: CAN FD CRC field serializer with fixed stuff bits; CAN_CRC_STUFF_DELIM_EN adds the CRC delimiter bit
module can_crc_stuff
    import can_fd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_en,
    input  logic               start,
    input  logic               crc_sel,
    input  logic [CRC17_W-1:0] crc_17_i,
    input  logic [CRC21_W-1:0] crc_21_i,
    input  logic               prev_bit,
    input  logic               abort,
    output logic               tx_bit,
    output logic               tx_valid,
    output logic               stuff_flag,
    output logic [4:0]         bit_cnt,
    output logic               busy,
    output logic               done
);
    tx_state_e          state, state_n;
    crc_sel_e           sel, sel_n;
    logic [CRC21_W-1:0] sr, sr_n;
    logic               last_bit, last_bit_n;
    logic               tx_bit_n, tx_valid_n, stuff_n, busy_n, done_n;
    logic [4:0]         cnt_n;
    logic               is_stuff, is_last, emit;

    can_fixed_stuff_pos u_pos (
        .bit_cnt      (bit_cnt),
        .crc_sel      (sel),
        .is_stuff_pos (is_stuff),
        .is_last_pos  (is_last)
    );

    // next-state and next-output logic; everything holds unless a bit_en or control event occurs
    always_comb begin
        state_n    = state;
        sel_n      = sel;
        sr_n       = sr;
        last_bit_n = last_bit;
        tx_bit_n   = tx_bit;
        tx_valid_n = tx_valid;
        stuff_n    = stuff_flag;
        cnt_n      = bit_cnt;
        busy_n     = busy;
        done_n     = 1'b0;
        emit       = is_stuff ? ~last_bit : sr[CRC21_W-1];
        if (abort) begin
            state_n    = IDLE;
            sr_n       = '0;
            last_bit_n = 1'b0;
            tx_bit_n   = 1'b1;
            tx_valid_n = 1'b0;
            stuff_n    = 1'b0;
            cnt_n      = 5'd0;
            busy_n     = 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sel_n      = crc_sel_e'(crc_sel);
                    sr_n       = crc_sel ? crc_21_i : {crc_17_i, {(CRC21_W-CRC17_W){1'b0}}};
                    last_bit_n = prev_bit;
                    cnt_n      = 5'd0;
                    busy_n     = 1'b1;
                    state_n    = SEND;
                end
                SEND: if (bit_en) begin
                    tx_bit_n   = emit;
                    stuff_n    = is_stuff;
                    sr_n       = is_stuff ? sr : {sr[CRC21_W-2:0], 1'b0};
                    last_bit_n = emit;
                    tx_valid_n = 1'b1;
                    cnt_n      = is_last ? bit_cnt : bit_cnt + 5'd1;
                    state_n    = is_last ? LAST : SEND;
                end
`ifdef CAN_CRC_STUFF_DELIM_EN
                LAST: if (bit_en) begin
                    tx_bit_n   = 1'b1;
                    tx_valid_n = 1'b1;
                    stuff_n    = 1'b0;
                    cnt_n      = bit_cnt + 5'd1;
                    state_n    = DELIM;
                end
                DELIM: if (bit_en) begin
                    tx_bit_n   = 1'b1;
                    tx_valid_n = 1'b0;
                    stuff_n    = 1'b0;
                    cnt_n      = 5'd0;
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end
`else
                LAST: if (bit_en) begin
                    tx_bit_n   = 1'b1;
                    tx_valid_n = 1'b0;
                    stuff_n    = 1'b0;
                    cnt_n      = 5'd0;
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end
                DELIM: state_n = IDLE;
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= CRC_17;
            sr         <= '0;
            last_bit   <= 1'b0;
            tx_bit     <= 1'b1;
            tx_valid   <= 1'b0;
            stuff_flag <= 1'b0;
            bit_cnt    <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            sr         <= sr_n;
            last_bit   <= last_bit_n;
            tx_bit     <= tx_bit_n;
            tx_valid   <= tx_valid_n;
            stuff_flag <= stuff_n;
            bit_cnt    <= cnt_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end
endmodule

// File: doc/can_crc_stuff.md
Name: can_crc_stuff

Overview:
- Transmit-side CAN FD CRC field serializer.
- Takes a CRC-17 or CRC-21 value from the TX CRC generator and shifts it out MSB-first, one bit per bit-time strobe.
- Inserts a fixed stuff bit at every STUFF_PERIOD-th position, starting at position 0. Each stuff bit is the complement of the previously transmitted bit.
- Sits between the TX CRC generator and the bit-stream mux feeding the TX bit-timing logic. It is the counterpart of the RX CRC destuffer, which expects stuff bits at positions 0, 5, 10, 15, 20, 25.

Parameters:
- CRC17_W, 17, CRC-17 width (data length ≤ 16 bytes)
- CRC21_W, 21, CRC-21 width (data length > 16 bytes)
- STUFF_PERIOD, 5, distance between fixed stuff positions (stuff bit + 4 data bits)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- bit_en  in  1  one-cycle strobe per transmitted bit time
- start  in  1  one-cycle request to begin the CRC field
- crc_sel  in  1  0 = CRC-17, 1 = CRC-21; sampled on an accepted start
- crc_17_i  in  17  CRC-17 value; sampled on an accepted start
- crc_21_i  in  21  CRC-21 value; sampled on an accepted start
- prev_bit  in  1  last bit of the preceding field (stuff count); sampled on an accepted start
- abort  in  1  error/arbitration loss; cancels the field
- tx_bit  out  1  current transmitted bit, registered
- tx_valid  out  1  tx_bit belongs to the CRC field
- stuff_flag  out  1  tx_bit is a fixed stuff bit
- bit_cnt  out  5  current position within the field
- busy  out  1  field in progress
- done  out  1  one-cycle pulse after the last bit is emitted

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces:
  - state=IDLE
  - tx_bit=1 (recessive)
  - tx_valid, stuff_flag, busy, done = 0
  - bit_cnt=0
  - shift register and last_bit = 0
- Reset mid-field: same result on the next edge; no done pulse is issued.
- States: IDLE, SEND, LAST.
- IDLE + start (abort=0):
  - Load the shift register with crc_17_i (left-aligned) or crc_21_i according to crc_sel.
  - Latch last_bit=prev_bit and field length: 22 positions for CRC-17, 27 for CRC-21.
  - Set bit_cnt=0, busy=1, go to SEND.
  - start while busy is ignored.
- SEND, on bit_en:
  - stuff position (bit_cnt % STUFF_PERIOD == 0): tx_bit <= ~last_bit, stuff_flag <= 1, shift register held.
  - otherwise: tx_bit <= shift MSB, stuff_flag <= 0, shift left by one.
  - In both cases: last_bit <= emitted bit, tx_valid <= 1, bit_cnt increments after the bit is emitted.
  - When the final position is emitted (21 for CRC-17, 26 for CRC-21), go to LAST.
- No bit_en: all outputs hold.
- LAST, on the next bit_en (end of the last bit time):
  - tx_valid=0, tx_bit=1, busy=0.
  - done=1 for exactly one clk.
  - Return to IDLE.
- abort in SEND or LAST: next edge goes to IDLE with outputs at their reset values and no done pulse. abort has priority over start and bit_en.
- start and bit_en in the same IDLE cycle: start is accepted; the first bit (position 0) is emitted on the next bit_en, not this one.
- bit_cnt is modulo-free: the maximum value is 26, within 5 bits.
- A stuff bit never appears after the last CRC data bit.

Optional Feature:
- Macro: CAN_CRC_STUFF_DELIM_EN.
- When defined:
  - LAST emits one extra recessive CRC delimiter bit on its bit_en: tx_bit=1, tx_valid=1, stuff_flag=0, bit_cnt = length.
  - done pulses on the following bit_en.
  - Adds state DELIM between LAST and IDLE.
- When undefined: no delimiter; the downstream field mux supplies it.

Decomposition:
- Package can_fd_pkg:
  - CRC17_W, CRC21_W, STUFF_PERIOD constants
  - crc_sel_e enum (CRC_17, CRC_21)
  - tx_state_e enum
  - field length constants 22/27
- Sub-module can_fixed_stuff_pos (combinational): bit_cnt and crc_sel → is_stuff_pos and is_last_pos. The RX destuffer can share it.

Test Plan:
- CRC-17 all zeros: crc_sel=0, crc_17_i=17'h0, prev_bit=0, 22 bit_en.
  - tx_bit = 1 0000 1 0000 1 0000 1 0000 1 0.
  - stuff_flag set at positions 0, 5, 10, 15, 20.
  - done pulses one bit_en later.
- CRC-21 all ones: crc_sel=1, crc_21_i=21'h1FFFFF, prev_bit=1.
  - tx_bit = 0 1111 0 1111 0 1111 0 1111 0 1111 0 1.
  - 27 bits; busy drops after done.
- CRC-17 = 17'h15555, prev_bit=1: each stuff bit equals ~(preceding data bit). The full stream, after removing positions 0, 5, 10, 15, 20, reproduces 17'h15555 MSB-first.
- abort asserted at bit_cnt=7 in SEND: next clk gives busy=0, tx_valid=0, tx_bit=1, and no done. A new start afterwards restarts at bit_cnt=0.
- Timing corner cases:
  - start and bit_en in the same cycle: first bit on the next bit_en.
  - start while busy: ignored, field unchanged.
  - rst pulse mid-field: all outputs return to reset values on the next edge.
- CAN_CRC_STUFF_DELIM_EN defined, CRC-17: position 22 is tx_bit=1 with stuff_flag=0; done one bit_en after it.
